// File: rtl/servo_pkg.sv
// Shared servo definitions: default clock/tick rates, pulse limits, decoder state
// encoding and a saturating counter helper used by the pulse decoder.
package servo_pkg;

    localparam int unsigned SERVO_CLK_HZ     = 100_000_000;
    localparam int unsigned SERVO_TICK_HZ    = 1_000_000;
    localparam int unsigned SERVO_MIN_US     = 500;
    localparam int unsigned SERVO_MAX_US     = 2500;
    localparam int unsigned SERVO_TIMEOUT_US = 25000;

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } dec_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/servo_pulse_decoder_if.sv
// PWM input and decoded measurement outputs of the servo pulse decoder.
interface servo_pulse_decoder_if;

    logic        pwm_in;
    logic [11:0] pulse_us;
    logic [15:0] period_us;
    logic        pulse_valid;
    logic        range_err;
    logic        signal_lost;

    // master: the decoder; slave: the PWM source / consumer of the measurements
    modport master (
        input  pwm_in,
        output pulse_us, period_us, pulse_valid, range_err, signal_lost
    );

    modport slave (
        output pwm_in,
        input  pulse_us, period_us, pulse_valid, range_err, signal_lost
    );

endinterface

// File: rtl/us_tick_gen.sv
// Divides the system clock by DIV to give a one-cycle measurement tick;
// restart re-aligns the phase so a tick lands DIV cycles after the restart.
module us_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == W'(DIV - 1))) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo PWM high-time and rise-to-rise period in ticks, flags
// out-of-range pulses and declares signal loss after an edge-free timeout.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ     = SERVO_CLK_HZ,
    parameter int unsigned TICK_HZ    = SERVO_TICK_HZ,
    parameter int unsigned MIN_US     = SERVO_MIN_US,
    parameter int unsigned MAX_US     = SERVO_MAX_US,
    parameter int unsigned TIMEOUT_US = SERVO_TIMEOUT_US
) (
    input logic                   clk,
    input logic                   rst_n,
    servo_pulse_decoder_if.master bus
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    logic sync1, s2, s3;
    logic rise, fall, tick;

    // Synchronizer resets high so a line already high at reset release is
    // not mistaken for a rising edge; the FSM then waits to see it low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            s2    <= 1'b1;
            s3    <= 1'b1;
        end else begin
            sync1 <= bus.pwm_in;
            s2    <= sync1;
            s3    <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    us_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (rise),
        .tick    (tick)
    );

    dec_state_t  state;
    logic [15:0] hi_cnt, per_cnt, idle_cnt;
    logic [15:0] hi_eff, per_eff, idle_eff;
    logic        have_frame;
    logic        in_range, timeout, active;
    logic [11:0] pulse_q;
    logic [15:0] period_q;
    logic        valid_q, err_q, lost_q;

    // A tick coinciding with the terminating edge still belongs to the
    // interval, so widths come out as floor(cycles / DIV).
    assign hi_eff   = sat_inc(hi_cnt, tick);
    assign per_eff  = sat_inc(per_cnt, tick);
    assign idle_eff = sat_inc(idle_cnt, tick);
    assign in_range = (hi_eff >= 16'(MIN_US)) && (hi_eff <= 16'(MAX_US));
    assign timeout  = (idle_cnt >= 16'(TIMEOUT_US));
    assign active   = (state == WAIT_RISE) || (state == HIGH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            hi_cnt     <= '0;
            per_cnt    <= '0;
            idle_cnt   <= '0;
            have_frame <= 1'b0;
            pulse_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            lost_q     <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state)
                SYNC: begin
                    hi_cnt     <= '0;
                    per_cnt    <= '0;
                    idle_cnt   <= '0;
                    have_frame <= 1'b0;
                    if (!s2) state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        if (have_frame) period_q <= per_eff;
                        have_frame <= 1'b1;
                        hi_cnt     <= '0;
                        per_cnt    <= '0;
                        idle_cnt   <= '0;
                        state      <= HIGH;
                    end else begin
                        per_cnt  <= per_eff;
                        idle_cnt <= idle_eff;
                    end
                end
                HIGH: begin
                    per_cnt <= per_eff;
                    if (fall) begin
                        if (in_range) begin
                            pulse_q <= hi_eff[11:0];
                            valid_q <= 1'b1;
                            lost_q  <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                        idle_cnt <= '0;
                        state    <= WAIT_RISE;
                    end else begin
                        hi_cnt   <= hi_eff;
                        idle_cnt <= idle_eff;
                    end
                end
                default: state <= SYNC;
            endcase

            // Placed after the case so a pulse ending on the timeout cycle is
            // still reported before the loss is declared.
            if (active && timeout) begin
                lost_q   <= 1'b1;
                hi_cnt   <= '0;
                per_cnt  <= '0;
                idle_cnt <= '0;
                state    <= SYNC;
            end
        end
    end

    assign bus.pulse_us    = pulse_q;
    assign bus.period_us   = period_q;
    assign bus.pulse_valid = valid_q;
    assign bus.range_err   = err_q;
    assign bus.signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder with scaled timing (4 clocks per tick) and a
// frame-level reference model of accepted width, period and loss status.
module tb_servo_pulse_decoder;

    localparam int unsigned DIV    = 4;
    localparam int unsigned MIN_US = 50;
    localparam int unsigned MAX_US = 250;
    localparam int unsigned TMO    = 600;

    logic clk;
    logic rst_n;

    servo_pulse_decoder_if bus ();

    servo_pulse_decoder #(
        .CLK_HZ     (400),
        .TICK_HZ    (100),
        .MIN_US     (MIN_US),
        .MAX_US     (MAX_US),
        .TIMEOUT_US (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int   nvalid = 0, nerr = 0, nboth = 0, nrun = 0;
    logic prev_v = 1'b0, prev_e = 1'b0;

    int   exp_pulse, exp_period, exp_valid, exp_err;
    logic exp_lost;
    int   frames_since_sync, last_rise, hi_start;
    bit   armed, measuring;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pulse_valid === 1'b1) nvalid++;
        if (bus.range_err === 1'b1) nerr++;
        if ((bus.pulse_valid === 1'b1) && (bus.range_err === 1'b1)) nboth++;
        if (((bus.pulse_valid === 1'b1) && prev_v) || ((bus.range_err === 1'b1) && prev_e)) nrun++;
        prev_v = (bus.pulse_valid === 1'b1);
        prev_e = (bus.range_err === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: frame-level rules on rise/fall events.
    task automatic m_reset();
        exp_pulse         = 0;
        exp_period        = 0;
        exp_lost          = 1'b1;
        frames_since_sync = 0;
        measuring         = 1'b0;
        armed             = (bus.pwm_in == 1'b0);
    endtask

    task automatic m_timeout();
        exp_lost          = 1'b1;
        frames_since_sync = 0;
        measuring         = 1'b0;
        armed             = (bus.pwm_in == 1'b0);
    endtask

    task automatic set_pwm(input logic v);
        int w;
        if (v && !bus.pwm_in) begin
            hi_start = cyc;
            if (armed) begin
                if (frames_since_sync >= 1) begin
                    exp_period = (cyc - last_rise) / DIV;
                    if (exp_period > 65535) exp_period = 65535;
                end
                frames_since_sync++;
                last_rise = cyc;
                measuring = 1'b1;
            end
        end else if (!v && bus.pwm_in) begin
            if (measuring) begin
                w = (cyc - hi_start) / DIV;
                if (w >= MIN_US && w <= MAX_US) begin
                    exp_pulse = w;
                    exp_valid++;
                    exp_lost  = 1'b0;
                end else begin
                    exp_err++;
                end
            end
            measuring = 1'b0;
            armed     = 1'b1;
        end
        bus.pwm_in = v;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pulse_us"},    32'(bus.pulse_us),    32'(exp_pulse));
        chk({tag, ".period_us"},   32'(bus.period_us),   32'(exp_period));
        chk({tag, ".valid_count"}, 32'(nvalid),          32'(exp_valid));
        chk({tag, ".err_count"},   32'(nerr),            32'(exp_err));
        chk({tag, ".signal_lost"}, 32'(bus.signal_lost), 32'(exp_lost));
    endtask

    task automatic frame(input int h, input int l, input string tag);
        set_pwm(1'b1);
        wait_cyc(h);
        set_pwm(1'b0);
        wait_cyc(l);
        check_all(tag);
    endtask

    initial begin
        exp_valid  = 0;
        exp_err    = 0;
        last_rise  = 0;
        hi_start   = 0;
        bus.pwm_in = 1'b0;
        rst_n      = 1'b0;
        m_reset();
        wait_cyc(3);
        check_all("reset");

        rst_n = 1'b1;
        m_reset();
        wait_cyc(10);

        for (int i = 0; i < 3; i++) frame(150 * DIV, 250 * DIV, "nominal");

        frame(50 * DIV,  350 * DIV, "min_ok");
        frame(250 * DIV, 150 * DIV, "max_ok");
        frame(49 * DIV,  351 * DIV, "below_min");
        frame(251 * DIV, 149 * DIV, "above_max");

        for (int i = 0; i < 12; i++)
            frame(int'($urandom_range(1040, 160)), int'($urandom_range(1200, 20)), "random");

        // line held low after a good pulse
        set_pwm(1'b1);
        wait_cyc(120 * DIV);
        set_pwm(1'b0);
        wait_cyc((TMO - 1) * DIV);
        check_all("low_pre_timeout");
        wait_cyc(DIV + 6);
        m_timeout();
        check_all("low_timeout");
        wait_cyc(600);
        frame(150 * DIV, 250 * DIV, "low_recover1");
        frame(150 * DIV, 250 * DIV, "low_recover2");

        // line stuck high
        set_pwm(1'b1);
        wait_cyc((TMO - 1) * DIV);
        check_all("high_pre_timeout");
        wait_cyc(DIV + 6);
        m_timeout();
        check_all("high_timeout");
        wait_cyc(600);
        set_pwm(1'b0);
        wait_cyc(20);
        check_all("high_release");
        frame(150 * DIV, 250 * DIV, "high_recover");

        // asynchronous reset in the middle of a pulse, released while high
        set_pwm(1'b1);
        wait_cyc(200);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all("async_reset");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(200);
        set_pwm(1'b0);
        wait_cyc(400);
        check_all("release_high");
        frame(180 * DIV, 220 * DIV, "after_reset");

        chk("strobe_exclusive", 32'(nboth), 32'd0);
        chk("strobe_width",     32'(nrun),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
